// File: rtl/banana_pkg.sv
// Shared types and constants for the banana sprite renderer.
package banana_pkg;

  typedef enum logic [1:0] {
    VISIBLE = 2'd0,
    SPARKLE = 2'd1,
    HIDDEN  = 2'd2
  } state_t;

  localparam logic [7:0] TRANSPARENT_IDX = 8'd0;
  localparam int         SPARKLE_VS      = 8;

  // One extra frame slot is reserved for the sparkle image.
  function automatic int calc_addr_w(input int num_frames, input int sprite_w, input int sprite_h);
    return $clog2((num_frames + 1) * sprite_w * sprite_h);
  endfunction

endpackage

// File: rtl/banana_hit_addr.sv
// Stage 1 of the pixel pipeline: sprite hit test and sprite-ROM address generation.
module banana_hit_addr #(
  parameter int COORD_W  = 10,
  parameter int SPRITE_W = 16,
  parameter int SPRITE_H = 16,
  parameter int FRAME_W  = 3,
  parameter int ADDR_W   = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_valid,
  input  logic [COORD_W-1:0] draw_x,
  input  logic [COORD_W-1:0] draw_y,
  input  logic [COORD_W-1:0] x_lat,
  input  logic [COORD_W-1:0] y_lat,
  input  logic [FRAME_W-1:0] draw_frame,
  input  logic               draw_en,
  output logic [ADDR_W-1:0]  rom_addr,
  output logic               hit_s1,
  output logic               draw_en_s1,
  output logic               valid_s1
);
  import banana_pkg::*;

  logic signed [COORD_W:0] dx;
  logic signed [COORD_W:0] dy;
  logic                    hit;
  logic [ADDR_W-1:0]       addr;

  // The sign bit rejects pixels left of / above the sprite, so no wrap-around hits at screen edges.
  always_comb begin
    dx   = $signed({1'b0, draw_x}) - $signed({1'b0, x_lat});
    dy   = $signed({1'b0, draw_y}) - $signed({1'b0, y_lat});
    hit  = !dx[COORD_W] && (dx[COORD_W-1:0] < COORD_W'(SPRITE_W)) &&
           !dy[COORD_W] && (dy[COORD_W-1:0] < COORD_W'(SPRITE_H));
    addr = '0;
    if (hit) begin
      addr = ADDR_W'(draw_frame) * ADDR_W'(SPRITE_W * SPRITE_H)
           + ADDR_W'(dy[COORD_W-1:0]) * ADDR_W'(SPRITE_W)
           + ADDR_W'(dx[COORD_W-1:0]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rom_addr   <= '0;
      hit_s1     <= 1'b0;
      draw_en_s1 <= 1'b0;
      valid_s1   <= 1'b0;
    end else begin
      valid_s1   <= pix_valid;
      hit_s1     <= pix_valid && hit;
      draw_en_s1 <= draw_en;
      if (pix_valid) begin
        rom_addr <= addr;
      end
    end
  end

endmodule

// File: rtl/banana_sprite_renderer.sv
// Banana sprite renderer: per-frame latch, 2-stage pixel pipeline, collect/respawn FSM.
// Optional sparkle animation on collection is enabled with `define BANANA_SPARKLE_EN.
module banana_sprite_renderer #(
  parameter int          SPRITE_W        = 16,
  parameter int          SPRITE_H        = 16,
  parameter int          NUM_FRAMES      = 7,
  parameter int          COORD_W         = 10,
  parameter int          RESPAWN_VS      = 120,
  parameter logic [7:0]  TRANSPARENT_IDX = banana_pkg::TRANSPARENT_IDX,
  parameter int          ADDR_W          = banana_pkg::calc_addr_w(NUM_FRAMES, SPRITE_W, SPRITE_H)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [18:0]        frame_num,
  input  logic               vsync_pulse,
  input  logic [COORD_W-1:0] banana_x,
  input  logic [COORD_W-1:0] banana_y,
  input  logic               collide,
  input  logic               pix_valid,
  input  logic [COORD_W-1:0] draw_x,
  input  logic [COORD_W-1:0] draw_y,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [7:0]         rom_data,
  output logic               pix_out_valid,
  output logic               pix_is_banana,
  output logic [7:0]         pix_color_idx,
  output logic               collected_pulse,
  output logic [7:0]         banana_count
);
  import banana_pkg::*;

  localparam int FRAME_W = 3;
  localparam int RESP_W  = $clog2(RESPAWN_VS + 1);

  logic [FRAME_W-1:0] frame_lat;
  logic [COORD_W-1:0] x_lat;
  logic [COORD_W-1:0] y_lat;

  state_t             state;
  state_t             state_next;
  logic [RESP_W-1:0]  respawn_cnt;
  logic [RESP_W-1:0]  respawn_next;
  logic               draw_en;
  logic [FRAME_W-1:0] draw_frame;
  logic               collect;
`ifdef BANANA_SPARKLE_EN
  logic [3:0]         sparkle_cnt;
  logic [3:0]         sparkle_next;
`endif

  logic               hit_s1;
  logic               draw_en_s1;
  logic               valid_s1;
  logic               is_banana;

  // Frame index and position change only at vsync so a frame is never drawn half-old, half-new.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_lat <= '0;
      x_lat     <= '0;
      y_lat     <= '0;
    end else if (vsync_pulse) begin
      frame_lat <= (frame_num < 19'(NUM_FRAMES)) ? frame_num[FRAME_W-1:0] : '0;
      x_lat     <= banana_x;
      y_lat     <= banana_y;
    end
  end

  always_comb begin
    state_next   = state;
    respawn_next = respawn_cnt;
    draw_en      = 1'b0;
    draw_frame   = frame_lat;
    collect      = 1'b0;
`ifdef BANANA_SPARKLE_EN
    sparkle_next = sparkle_cnt;
`endif
    case (state)
      VISIBLE: begin
        draw_en = 1'b1;
        if (collide) begin
          collect      = 1'b1;
          respawn_next = '0;
`ifdef BANANA_SPARKLE_EN
          sparkle_next = '0;
          state_next   = SPARKLE;
`else
          state_next   = HIDDEN;
`endif
        end
      end
`ifdef BANANA_SPARKLE_EN
      SPARKLE: begin
        draw_en    = 1'b1;
        draw_frame = FRAME_W'(NUM_FRAMES);
        if (vsync_pulse) begin
          if (sparkle_cnt == 4'(SPARKLE_VS - 1)) begin
            sparkle_next = '0;
            respawn_next = '0;
            state_next   = HIDDEN;
          end else begin
            sparkle_next = sparkle_cnt + 4'd1;
          end
        end
      end
`endif
      HIDDEN: begin
        if (vsync_pulse) begin
          if (respawn_cnt == RESP_W'(RESPAWN_VS - 1)) begin
            respawn_next = '0;
            state_next   = VISIBLE;
          end else begin
            respawn_next = respawn_cnt + RESP_W'(1);
          end
        end
      end
      default: state_next = VISIBLE;
    endcase
  end

  // Leaving VISIBLE on the same edge as the collection guarantees one count per episode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= VISIBLE;
      respawn_cnt     <= '0;
      collected_pulse <= 1'b0;
      banana_count    <= 8'd0;
`ifdef BANANA_SPARKLE_EN
      sparkle_cnt     <= '0;
`endif
    end else begin
      state           <= state_next;
      respawn_cnt     <= respawn_next;
      collected_pulse <= collect;
      if (collect && (banana_count != 8'hFF)) begin
        banana_count <= banana_count + 8'd1;
      end
`ifdef BANANA_SPARKLE_EN
      sparkle_cnt     <= sparkle_next;
`endif
    end
  end

  banana_hit_addr #(
    .COORD_W  (COORD_W),
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H),
    .FRAME_W  (FRAME_W),
    .ADDR_W   (ADDR_W)
  ) u_hit_addr (
    .clk        (clk),
    .reset      (reset),
    .pix_valid  (pix_valid),
    .draw_x     (draw_x),
    .draw_y     (draw_y),
    .x_lat      (x_lat),
    .y_lat      (y_lat),
    .draw_frame (draw_frame),
    .draw_en    (draw_en),
    .rom_addr   (rom_addr),
    .hit_s1     (hit_s1),
    .draw_en_s1 (draw_en_s1),
    .valid_s1   (valid_s1)
  );

  assign is_banana = hit_s1 && draw_en_s1 && (rom_data != TRANSPARENT_IDX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_out_valid <= 1'b0;
      pix_is_banana <= 1'b0;
      pix_color_idx <= 8'd0;
    end else begin
      pix_out_valid <= valid_s1;
      pix_is_banana <= is_banana;
      pix_color_idx <= is_banana ? rom_data : 8'd0;
    end
  end

endmodule

// File: tb/tb_banana_sprite_renderer.sv
// Directed, table-driven bench for banana_sprite_renderer (default parameters).
module tb_banana_sprite_renderer;

  localparam int ADDR_W = 11;
`ifdef BANANA_SPARKLE_EN
  localparam int HIDE_VS = 8 + 120;
`else
  localparam int HIDE_VS = 120;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [18:0]       frame_num = '0;
  logic              vsync_pulse = 1'b0;
  logic [9:0]        banana_x = '0;
  logic [9:0]        banana_y = '0;
  logic              collide = 1'b0;
  logic              pix_valid = 1'b0;
  logic [9:0]        draw_x = '0;
  logic [9:0]        draw_y = '0;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data = '0;
  logic              pix_out_valid;
  logic              pix_is_banana;
  logic [7:0]        pix_color_idx;
  logic              collected_pulse;
  logic [7:0]        banana_count;

  int total_cnt = 0;
  int pass_cnt  = 0;

  always #5 clk = ~clk;

  banana_sprite_renderer dut (
    .clk             (clk),
    .reset           (reset),
    .frame_num       (frame_num),
    .vsync_pulse     (vsync_pulse),
    .banana_x        (banana_x),
    .banana_y        (banana_y),
    .collide         (collide),
    .pix_valid       (pix_valid),
    .draw_x          (draw_x),
    .draw_y          (draw_y),
    .rom_addr        (rom_addr),
    .rom_data        (rom_data),
    .pix_out_valid   (pix_out_valid),
    .pix_is_banana   (pix_is_banana),
    .pix_color_idx   (pix_color_idx),
    .collected_pulse (collected_pulse),
    .banana_count    (banana_count)
  );

  typedef struct {
    logic [18:0]       frame;
    logic [9:0]        bx;
    logic [9:0]        by;
    logic [9:0]        x;
    logic [9:0]        y;
    logic [7:0]        rdata;
    logic [ADDR_W-1:0] exp_addr;
    logic              exp_is;
    logic [7:0]        exp_idx;
  } vec_t;

  vec_t vecs[11];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic latchFrame(input logic [18:0] f, input logic [9:0] bx, input logic [9:0] by);
    @(negedge clk);
    frame_num = f; banana_x = bx; banana_y = by; vsync_pulse = 1'b1;
    @(negedge clk);
    vsync_pulse = 1'b0;
  endtask

  // Pixel issued at a negedge; rom_addr read 1 edge later, ROM data supplied, outputs read 2 edges later.
  task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y, input logic [7:0] rdata,
                               output logic [ADDR_W-1:0] addr);
    @(negedge clk);
    pix_valid = 1'b1; draw_x = x; draw_y = y;
    @(posedge clk); #1;
    addr = rom_addr;
    pix_valid = 1'b0; rom_data = rdata;
    @(posedge clk); #1;
  endtask

  task automatic checkPixel(input string name, input logic [9:0] x, input logic [9:0] y,
                            input logic [7:0] rdata, input logic exp_is, input logic [7:0] exp_idx);
    logic [ADDR_W-1:0] a;
    applyStimulus(x, y, rdata, a);
    checkOutput({name, "_valid"}, 32'(pix_out_valid), 32'd1);
    checkOutput({name, "_is"}, 32'(pix_is_banana), 32'(exp_is));
    checkOutput({name, "_idx"}, 32'(pix_color_idx), 32'(exp_idx));
  endtask

  task automatic respawnWait(input int n);
    @(negedge clk);
    vsync_pulse = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    vsync_pulse = 1'b0;
  endtask

  task automatic collectOnce(output int pulses);
    pulses = 0;
    @(negedge clk);
    collide = 1'b1;
    @(posedge clk); #1;
    if (collected_pulse) pulses++;
    collide = 1'b0;
  endtask

  initial begin
    logic [ADDR_W-1:0] a;
    int pulses;
    int p;

    vecs[0]  = '{19'd3, 10'd100, 10'd50, 10'd105, 10'd52, 8'h2A, 11'd805, 1'b1, 8'h2A};
    vecs[1]  = '{19'd9, 10'd100, 10'd50, 10'd100, 10'd50, 8'h11, 11'd0, 1'b1, 8'h11};
    vecs[2]  = '{19'd2, 10'd100, 10'd50, 10'd99, 10'd50, 8'h55, 11'd0, 1'b0, 8'h00};
    vecs[3]  = '{19'd2, 10'd100, 10'd50, 10'd116, 10'd50, 8'h55, 11'd0, 1'b0, 8'h00};
    vecs[4]  = '{19'd2, 10'd100, 10'd50, 10'd100, 10'd66, 8'h55, 11'd0, 1'b0, 8'h00};
    vecs[5]  = '{19'd1, 10'd0, 10'd0, 10'd3, 10'd3, 8'h44, 11'd307, 1'b1, 8'h44};
    vecs[6]  = '{19'd1, 10'd10, 10'd10, 10'd0, 10'd0, 8'h44, 11'd0, 1'b0, 8'h00};
    vecs[7]  = '{19'd6, 10'd200, 10'd300, 10'd215, 10'd315, 8'h00, 11'd1791, 1'b0, 8'h00};
    vecs[8]  = '{19'd7, 10'd200, 10'd300, 10'd200, 10'd300, 8'h80, 11'd0, 1'b1, 8'h80};
    vecs[9]  = '{19'd4, 10'd1008, 10'd1000, 10'd1023, 10'd1015, 8'hFF, 11'd1279, 1'b1, 8'hFF};
    vecs[10] = '{19'd5, 10'd100, 10'd50, 10'd115, 10'd65, 8'h01, 11'd1535, 1'b1, 8'h01};

    #22;
    checkOutput("rst_out_valid", 32'(pix_out_valid), 32'd0);
    checkOutput("rst_is_banana", 32'(pix_is_banana), 32'd0);
    checkOutput("rst_color_idx", 32'(pix_color_idx), 32'd0);
    checkOutput("rst_pulse", 32'(collected_pulse), 32'd0);
    checkOutput("rst_count", 32'(banana_count), 32'd0);
    checkOutput("rst_rom_addr", 32'(rom_addr), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 11; i++) begin
      latchFrame(vecs[i].frame, vecs[i].bx, vecs[i].by);
      applyStimulus(vecs[i].x, vecs[i].y, vecs[i].rdata, a);
      checkOutput($sformatf("vec%0d_addr", i), 32'(a), 32'(vecs[i].exp_addr));
      checkOutput($sformatf("vec%0d_valid", i), 32'(pix_out_valid), 32'd1);
      checkOutput($sformatf("vec%0d_is", i), 32'(pix_is_banana), 32'(vecs[i].exp_is));
      checkOutput($sformatf("vec%0d_idx", i), 32'(pix_color_idx), 32'(vecs[i].exp_idx));
    end

    // Inputs change without vsync: latched frame/position must hold.
    latchFrame(19'd3, 10'd100, 10'd50);
    frame_num = 19'd5; banana_x = 10'd0;
    applyStimulus(10'd105, 10'd52, 8'h2A, a);
    checkOutput("no_tear_addr", 32'(a), 32'd805);
    frame_num = 19'd3; banana_x = 10'd100;

    // Held collide: one pulse, one count.
    pulses = 0;
    @(negedge clk);
    collide = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (collected_pulse) pulses++;
    end
    collide = 1'b0;
    @(posedge clk); #1;
    if (collected_pulse) pulses++;
    checkOutput("held_collide_pulses", 32'(pulses), 32'd1);
    checkOutput("held_collide_count", 32'(banana_count), 32'd1);

`ifdef BANANA_SPARKLE_EN
    applyStimulus(10'd105, 10'd52, 8'h3C, a);
    checkOutput("sparkle_addr", 32'(a), 32'd1829);
    checkOutput("sparkle_is", 32'(pix_is_banana), 32'd1);
    respawnWait(8);
`endif
    checkPixel("hidden", 10'd105, 10'd52, 8'h33, 1'b0, 8'h00);
    respawnWait(119);
    checkPixel("hidden_119", 10'd105, 10'd52, 8'h33, 1'b0, 8'h00);
    respawnWait(1);
    checkPixel("visible_120", 10'd105, 10'd52, 8'h33, 1'b1, 8'h33);

    // collide together with vsync: collection taken and the frame latch still moves.
    @(negedge clk);
    collide = 1'b1; vsync_pulse = 1'b1; frame_num = 19'd2;
    @(posedge clk); #1;
    checkOutput("collide_vsync_pulse", 32'(collected_pulse), 32'd1);
    checkOutput("collide_vsync_count", 32'(banana_count), 32'd2);
    collide = 1'b0; vsync_pulse = 1'b0;
    respawnWait(HIDE_VS);
    applyStimulus(10'd105, 10'd52, 8'h2A, a);
    checkOutput("collide_vsync_frame", 32'(a), 32'd549);

    // Drive the counter to saturation.
    pulses = 0;
    for (int k = 0; k < 253; k++) begin
      collectOnce(p);
      pulses += p;
      respawnWait(HIDE_VS);
    end
    checkOutput("sat_pulses", 32'(pulses), 32'd253);
    checkOutput("sat_count", 32'(banana_count), 32'd255);
    collectOnce(p);
    checkOutput("sat_extra_pulse", 32'(p), 32'd1);
    checkOutput("sat_extra_count", 32'(banana_count), 32'd255);
    respawnWait(HIDE_VS);

    // Async reset with pixels streaming.
    @(negedge clk);
    pix_valid = 1'b1; draw_x = 10'd105; draw_y = 10'd52; rom_data = 8'h2A;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("inflight_valid", 32'(pix_out_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_rst_valid", 32'(pix_out_valid), 32'd0);
    checkOutput("async_rst_is", 32'(pix_is_banana), 32'd0);
    checkOutput("async_rst_count", 32'(banana_count), 32'd0);
    pix_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_rst_count", 32'(banana_count), 32'd0);
    checkOutput("post_rst_pulse", 32'(collected_pulse), 32'd0);
    latchFrame(19'd3, 10'd100, 10'd50);
    applyStimulus(10'd105, 10'd52, 8'h2A, a);
    checkOutput("post_rst_addr", 32'(a), 32'd805);
    checkOutput("post_rst_is", 32'(pix_is_banana), 32'd1);
    checkOutput("post_rst_idx", 32'(pix_color_idx), 32'h2A);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
